// File: rtl/load_store_unit.sv
// RV32I load/store unit with a private word memory. Accesses that cross a word
// boundary take two memory cycles when MISALIGN_SPLIT=1; otherwise they report an error.
module load_store_unit #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned MISALIGN_SPLIT = 1
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StResp} state_e;

    state_e state_q, state_d;

    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       ea_q, ea_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [Depth];

    logic [1:0]        off;
    logic              is_byte, is_half, is_word;
    logic              legal, misaligned, crosses, split, acc_err;
    logic [3:0]        be4;
    logic [7:0]        wide_be;
    logic [63:0]       wide_wd;
    logic [ADDR_W-1:0] idx_w, idx_hi, mem_idx;
    logic [31:0]       mem_rd;
    logic [63:0]       load_wide, load_shift;
    logic [31:0]       lane, load_ext;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;

    // Access decode, always from the latched request.
    always_comb begin
        off        = ea_q[1:0];
        is_byte    = (funct3_q[1:0] == 2'b00);
        is_half    = (funct3_q[1:0] == 2'b01);
        is_word    = (funct3_q == 3'b010);
        if (store_q) begin
            legal = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010);
        end else begin
            legal = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                    (funct3_q == 3'b100) || (funct3_q == 3'b101);
        end
        misaligned = (is_half && off[0]) || (is_word && (off != 2'b00));
        crosses    = (is_half && (off == 2'b11)) || (is_word && (off != 2'b00));
        split      = legal && misaligned && (MISALIGN_SPLIT != 0) && crosses;
        acc_err    = !legal || (misaligned && (MISALIGN_SPLIT == 0));
        be4        = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);
        wide_be    = {4'b0000, be4} << off;
        wide_wd    = {32'h0, wdata_q} << {off, 3'b000};
    end

    assign idx_w   = ea_q[ADDR_W+1:2];
    assign idx_hi  = idx_w + ADDR_W'(1);
    assign mem_idx = (state_q == StAcc2) ? idx_hi : idx_w;
    assign mem_rd  = mem[mem_idx];

    // Second-word bytes sit above the first-word bytes so one shift aligns both cases.
    always_comb begin
        load_wide  = (state_q == StAcc2) ? {mem_rd, lo_q} : {32'h0, mem_rd};
        load_shift = load_wide >> {off, 3'b000};
        lane       = load_shift[31:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = StAcc1;
            StAcc1:  state_d = split ? StAcc2 : StResp;
            StAcc2:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        mem_we    = 4'b0000;
        mem_wdata = wide_wd[31:0];
        unique case (state_q)
            StAcc1: if (store_q && !acc_err) mem_we = wide_be[3:0];
            StAcc2: begin
                if (store_q) mem_we = wide_be[7:4];
                mem_wdata = wide_wd[63:32];
            end
            default: mem_we = 4'b0000;
        endcase
    end

    always_comb begin
        store_d  = store_q;
        funct3_d = funct3_q;
        ea_d     = ea_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    ea_d     = req_base + req_offset;
                    wdata_d  = req_wdata;
                end
            end
            StAcc1: begin
                lo_d = mem_rd;
                if (!split) begin
                    err_d   = acc_err;
                    rdata_d = (acc_err || store_q) ? 32'h0 : load_ext;
                end
            end
            StAcc2: begin
                err_d   = 1'b0;
                rdata_d = store_q ? 32'h0 : load_ext;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            ea_q     <= 32'h0;
            wdata_q  <= 32'h0;
            lo_q     <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            store_q  <= store_d;
            funct3_q <= funct3_d;
            ea_q     <= ea_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Memory contents intentionally survive reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (mem_we[l]) mem[mem_idx][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    logic unused_bits;
    assign unused_bits = ^{ea_q[31:ADDR_W+2], load_shift[63:32]};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with split mode, one with error mode,
// expected responses queued by the driver and checked by a forked monitor.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstd;
    logic [1:0]  req_valid, req_ready, req_store, rsp_valid, rsp_ready, rsp_err;
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_base [2];
    logic [31:0] req_offset [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];

    load_store_unit #(.ADDR_W(8), .MISALIGN_SPLIT(0)) u_dut0 (
        .clk(clk), .rstd(rstd),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_store(req_store[0]),
        .req_funct3(req_funct3[0]), .req_base(req_base[0]), .req_offset(req_offset[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    load_store_unit #(.ADDR_W(8), .MISALIGN_SPLIT(1)) u_dut1 (
        .clk(clk), .rstd(rstd),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_store(req_store[1]),
        .req_funct3(req_funct3[1]), .req_base(req_base[1]), .req_offset(req_offset[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   next_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit   seen [2];
        int   first [2];
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid[d] === 1'b1) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp dut%0d: rsp_valid=1, expected 0", d);
                    end else begin
                        e = (d == 0) ? q0[0] : q1[0];
                        if (!seen[d]) begin
                            seen[d]  = 1'b1;
                            first[d] = cyc;
                        end
                        chk($sformatf("dut%0d txn%0d rdata", d, e.id), rsp_rdata[d], e.rdata);
                        chk($sformatf("dut%0d txn%0d err", d, e.id), 32'(rsp_err[d]),
                            32'(e.err));
                        chk($sformatf("dut%0d txn%0d req_ready_in_resp", d, e.id),
                            32'(req_ready[d]), 32'd0);
                        if (rsp_ready[d] === 1'b1) begin
                            chk($sformatf("dut%0d txn%0d latency", d, e.id),
                                32'(first[d] - e.acc + 1), 32'(e.lat));
                            if (d == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                            seen[d] = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic accept(input int d, input logic st, input logic [2:0] f3,
                          input logic [31:0] b, input logic [31:0] o, input logic [31:0] w,
                          output int acc);
        int n = 0;
        req_store[d]  = st;
        req_funct3[d] = f3;
        req_base[d]   = b;
        req_offset[d] = o;
        req_wdata[d]  = w;
        req_valid[d]  = 1'b1;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout dut%0d: req_ready=%b, expected 1", d, req_ready[d]);
        end
        @(posedge clk); #1;
        acc          = cyc;
        req_valid[d] = 1'b0;
    endtask

    // hold > 0 keeps rsp_ready low for that many cycles once the response appears.
    task automatic issue(input int d, input logic st, input logic [2:0] f3,
                         input logic [31:0] b, input logic [31:0] o, input logic [31:0] w,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat,
                         input int hold);
        int   acc;
        int   n;
        exp_t e;
        rsp_ready[d] = (hold == 0);
        accept(d, st, f3, b, o, w, acc);
        e = '{rdata: exp_rd, err: exp_err, lat: lat, acc: acc, id: next_id};
        next_id++;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (hold > 0) begin
            n = 0;
            while (rsp_valid[d] !== 1'b1 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            repeat (hold) begin
                @(posedge clk); #1;
            end
            rsp_ready[d] = 1'b1;
        end
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL response_timeout dut%0d: req_ready=%b, expected 1", d, req_ready[d]);
        end
    endtask

    int acc_r;

    initial begin
        rstd      = 1'b0;
        req_valid = 2'b00;
        req_store = 2'b00;
        rsp_ready = 2'b11;
        for (int d = 0; d < 2; d++) begin
            req_funct3[d] = 3'b000;
            req_base[d]   = 32'h0;
            req_offset[d] = 32'h0;
            req_wdata[d]  = 32'h0;
        end
        fork
            monitor();
        join_none
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata1", rsp_rdata[1], 32'h0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        rstd = 1'b1;
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd3);

        // Split-mode instance.
        issue(1, 1, 3'b010, 32'h10, 32'h0, 32'h11223344, 32'h0, 0, 2, 0);
        issue(1, 0, 3'b010, 32'h08, 32'h8, 32'h0, 32'h11223344, 0, 2, 0);
        issue(1, 1, 3'b010, 32'h20, 32'h0, 32'h55667788, 32'h0, 0, 2, 0);
        issue(1, 1, 3'b000, 32'h22, 32'hFFFFFFFF, 32'h12345680, 32'h0, 0, 2, 0);
        issue(1, 0, 3'b000, 32'h21, 32'h0, 32'h0, 32'hFFFFFF80, 0, 2, 0);
        issue(1, 0, 3'b100, 32'h21, 32'h0, 32'h0, 32'h00000080, 0, 2, 0);
        issue(1, 0, 3'b010, 32'h20, 32'h0, 32'h0, 32'h55668088, 0, 2, 0);
        issue(1, 0, 3'b001, 32'h21, 32'h0, 32'h0, 32'h00006680, 0, 2, 0);
        issue(1, 0, 3'b001, 32'h20, 32'h0, 32'h0, 32'hFFFF8088, 0, 2, 0);
        issue(1, 0, 3'b101, 32'h22, 32'h0, 32'h0, 32'h00005566, 0, 2, 0);
        issue(1, 0, 3'b010, 32'h1000, 32'h20, 32'h0, 32'h55668088, 0, 2, 0);
        issue(1, 1, 3'b010, 32'h0C, 32'h0, 32'h01020304, 32'h0, 0, 2, 0);
        issue(1, 1, 3'b010, 32'h10, 32'h0, 32'h05060708, 32'h0, 0, 2, 0);
        issue(1, 1, 3'b010, 32'h0F, 32'h0, 32'hAABBCCDD, 32'h0, 0, 3, 0);
        issue(1, 0, 3'b010, 32'h0C, 32'h0, 32'h0, 32'hDD020304, 0, 2, 0);
        issue(1, 0, 3'b010, 32'h10, 32'h0, 32'h0, 32'h05AABBCC, 0, 2, 0);
        issue(1, 0, 3'b010, 32'h0F, 32'h0, 32'h0, 32'hAABBCCDD, 0, 3, 0);
        issue(1, 1, 3'b010, 32'h3FC, 32'h0, 32'h11111111, 32'h0, 0, 2, 0);
        issue(1, 1, 3'b010, 32'h0, 32'h0, 32'h22222222, 32'h0, 0, 2, 0);
        issue(1, 1, 3'b001, 32'h3FF, 32'h0, 32'h0000BEEF, 32'h0, 0, 3, 0);
        issue(1, 0, 3'b010, 32'h3FC, 32'h0, 32'h0, 32'hEF111111, 0, 2, 0);
        issue(1, 0, 3'b010, 32'hFFFFFFF0, 32'h10, 32'h0, 32'h222222BE, 0, 2, 0);
        issue(1, 0, 3'b001, 32'h3FF, 32'h0, 32'h0, 32'hFFFFBEEF, 0, 3, 0);
        issue(1, 0, 3'b101, 32'h3FF, 32'h0, 32'h0, 32'h0000BEEF, 0, 3, 0);
        issue(1, 0, 3'b011, 32'h20, 32'h0, 32'h0, 32'h0, 1, 2, 0);
        issue(1, 1, 3'b100, 32'h20, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 2, 0);
        issue(1, 0, 3'b010, 32'h20, 32'h0, 32'h0, 32'h55668088, 0, 2, 0);
        issue(1, 0, 3'b010, 32'h0C, 32'h0, 32'h0, 32'hDD020304, 0, 2, 5);

        // Error-mode instance.
        issue(0, 1, 3'b010, 32'h0, 32'h0, 32'h01020304, 32'h0, 0, 2, 0);
        issue(0, 1, 3'b001, 32'h03, 32'h0, 32'h0000BEEF, 32'h0, 1, 2, 0);
        issue(0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 32'h01020304, 0, 2, 0);
        issue(0, 0, 3'b010, 32'h02, 32'h0, 32'h0, 32'h0, 1, 2, 0);
        issue(0, 0, 3'b011, 32'h0, 32'h0, 32'h0, 32'h0, 1, 2, 0);
        issue(0, 0, 3'b000, 32'h03, 32'h0, 32'h0, 32'h00000001, 0, 2, 0);

        // Reset during the second word of a split store.
        issue(1, 1, 3'b010, 32'h40, 32'h0, 32'h33333333, 32'h0, 0, 2, 0);
        issue(1, 1, 3'b010, 32'h44, 32'h0, 32'h44444444, 32'h0, 0, 2, 0);
        accept(1, 1, 3'b010, 32'h42, 32'h0, 32'h99887766, acc_r);
        @(posedge clk); #1;
        rstd = 1'b0;
        #1;
        chk("midreset rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("midreset rsp_rdata", rsp_rdata[1], 32'h0);
        chk("midreset rsp_err", 32'(rsp_err[1]), 32'd0);
        @(posedge clk); #1;
        rstd = 1'b1;
        #1;
        chk("post_reset req_ready", 32'(req_ready[1]), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_reset rsp_valid", 32'(rsp_valid[1]), 32'd0);
        end
        issue(1, 0, 3'b010, 32'h40, 32'h0, 32'h0, 32'h77663333, 0, 2, 0);
        issue(1, 0, 3'b010, 32'h44, 32'h0, 32'h0, 32'h44444444, 0, 2, 0);

        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address bits; memory depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter MISALIGN_SPLIT, default 1: 1 = word-crossing accesses split into two cycles; 0 = misaligned accesses error.
REQ-003 SHALL have a single clock: clk  in  1  clock; all state updates on posedge.
REQ-004 SHALL have rstd  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have req_valid  in  1  request present.
REQ-006 SHALL have req_ready  out  1  unit can accept a request.
REQ-007 SHALL have req_store  in  1  0 = load, 1 = store.
REQ-008 SHALL have req_funct3  in  3  RV32I width/sign code.
REQ-009 SHALL have req_base  in  32  base register value.
REQ-010 SHALL have req_offset  in  32  sign-extended immediate (I-type for loads, S-type for stores).
REQ-011 SHALL have req_wdata  in  32  store source register.
REQ-012 SHALL have rsp_valid  out  1  response present.
REQ-013 SHALL have rsp_ready  in  1  consumer takes response.
REQ-014 SHALL have rsp_rdata  out  32  load result after extension; 0 for stores and errors.
REQ-015 SHALL have rsp_err  out  1  misaligned (mode 0) or illegal funct3.

Function
REQ-016 SHALL contain 2^ADDR_W x 32-bit memory: four byte lanes, per-lane write enable, combinational read, write on posedge clk.
REQ-017 SHALL compute ea = req_base + req_offset modulo 2^32 at acceptance, latched with all request fields.
REQ-018 SHALL form word index as ea[ADDR_W+1:2]; higher ea bits ignored, wrapping modulo depth.
REQ-019 SHALL use little-endian byte order: byte at ea[1:0]=k in lane k (bits 8k+7:8k).
REQ-020 SHALL accept loads with funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and stores with 000 SB, 001 SH, 010 SW; any other code sets rsp_err=1 with no memory write.
REQ-021 SHALL sign-extend LB/LH from bit 7/15 and zero-extend LBU/LHU.
REQ-022 SHALL use FSM states IDLE, ACC1, ACC2, RESP.
REQ-023 SHALL assert req_ready only in IDLE; acceptance is req_valid && req_ready at posedge, moving to ACC1.
REQ-024 SHALL in ACC1 access word index W: it performs the store lane writes or captures the load bytes, then goes to ACC2 if the access is split, else to RESP.
REQ-025 SHALL treat as misaligned a halfword with ea[0]=1 or a word with ea[1:0]!=00; an access is split when it is misaligned, MISALIGN_SPLIT=1, and its bytes span two words (LH/SH at ea[1:0]=11, or LW/SW at ea[1:0]!=00).
REQ-026 SHALL handle a misaligned access with MISALIGN_SPLIT=1 that does not cross a word (halfword at ea[1:0]=01) in ACC1 only.
REQ-027 SHALL in ACC2 access word index (W+1) modulo depth for the remaining upper bytes in lanes 0 upward, then go to RESP.
REQ-028 SHALL with MISALIGN_SPLIT=0 perform no memory write for a misaligned access and go ACC1 -> RESP with rsp_err=1 and rsp_rdata=0.
REQ-029 SHALL assert rsp_valid only in RESP and hold rsp_rdata/rsp_err stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-030 SHALL produce the earliest rsp_valid for an unsplit access 2 cycles after acceptance and for a split access 3 cycles after; next acceptance is possible on the cycle after the response handshake.
REQ-031 SHALL make a load following a store to the same bytes return the stored data.

Reset
REQ-032 SHALL, while rstd=0, force the FSM to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clear latched request registers; req_ready=1 after release.
REQ-033 SHALL not reset memory contents.
REQ-034 SHALL on reset mid-operation abandon the request with no response; a split store reset after ACC1 keeps its first-word bytes and never writes the second word.

Verification
REQ-035 SHALL pass: SW 0x11223344 at ea 0x10, then LW 0x10 -> rdata 0x11223344, err 0, response 2 cycles after each acceptance.
REQ-036 SHALL pass: SB 0x80 at ea 0x21, then LB 0x21 -> 0xFFFFFF80 and LBU 0x21 -> 0x00000080; LW 0x20 shows 0x80 only in bits 15:8 and other bytes unchanged.
REQ-037 SHALL pass with MISALIGN_SPLIT=1: SW 0xAABBCCDD at ea 0x0F -> word 0x0C byte 3 = 0xDD, word 0x10 bytes 0..2 = CC,BB,AA; LW 0x0F -> 0xAABBCCDD, latency 3.
REQ-038 SHALL pass with ADDR_W=8 and MISALIGN_SPLIT=1: LH at ea 0x3FF -> second access wraps to word 0; SH at ea 0x3FF writes byte 3 of word 255 and byte 0 of word 0.
REQ-039 SHALL pass with MISALIGN_SPLIT=0: SH at ea 0x03 -> err 1, rdata 0, memory unchanged; funct3 011 load -> err 1.
REQ-040 SHALL pass: with rsp_ready held 0 for 5 cycles, rsp_valid and data stay stable and req_ready stays 0; rstd pulsed during ACC2 of a split store -> only first-word bytes written, rsp_valid stays 0.
